// File: rtl/iob_axil_pbus_bridge.sv
// AXI4-Lite slave to N-way IOb peripheral bus bridge, one transaction in flight.
// Read/write fairness, DECERR for unmapped slaves, SLVERR on IOb timeout.
module iob_axil_pbus_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_SLAVES  = 4,
    parameter int unsigned P_SLAVES  = 26,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cke_i,
    input  logic [ADDR_W-1:0]            axil_awaddr_i,
    input  logic [2:0]                   axil_awprot_i,
    input  logic                         axil_awvalid_i,
    output logic                         axil_awready_o,
    input  logic [DATA_W-1:0]            axil_wdata_i,
    input  logic [DATA_W/8-1:0]          axil_wstrb_i,
    input  logic                         axil_wvalid_i,
    output logic                         axil_wready_o,
    output logic [1:0]                   axil_bresp_o,
    output logic                         axil_bvalid_o,
    input  logic                         axil_bready_i,
    input  logic [ADDR_W-1:0]            axil_araddr_i,
    input  logic [2:0]                   axil_arprot_i,
    input  logic                         axil_arvalid_i,
    output logic                         axil_arready_o,
    output logic [DATA_W-1:0]            axil_rdata_o,
    output logic [1:0]                   axil_rresp_o,
    output logic                         axil_rvalid_o,
    input  logic                         axil_rready_i,
    output logic [N_SLAVES-1:0]          s_avalid_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic [DATA_W/8-1:0]          s_wstrb_o,
    input  logic [N_SLAVES-1:0]          s_ready_i,
    input  logic [N_SLAVES-1:0]          s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [ADDR_W-1:0]    LO_MASK  = ADDR_W'((64'(1) << P_SLAVES) - 64'(1));
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~TIMEOUT_W'(1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, RD_REQ, RD_WAIT, B_RESP, R_RESP
    } state_t;

    state_t               r_state;
    logic                 r_last_wr;
    logic                 r_is_wr;
    logic                 r_mapped;
    logic [SEL_W-1:0]     r_sel;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [STRB_W-1:0]    r_wstrb;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_awready;
    logic                 r_wready;
    logic                 r_arready;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [1:0]           r_rresp;
    logic [DATA_W-1:0]    r_rdata;
    logic [N_SLAVES-1:0]  r_avalid;

    logic                 w_wr_elig;
    logic                 w_rd_elig;
    logic                 w_grant_wr;
    logic [ADDR_W-1:0]    w_gaddr;
    logic [SEL_W-1:0]     w_gsel;
    logic                 w_gmapped;
    logic                 w_acc;
    logic                 w_tmo;
    logic                 w_sel_ready;
    logic                 w_sel_rvalid;
    logic [DATA_W-1:0]    w_sel_rdata;
    logic                 w_unused;

    // Protection bits carry no meaning on the IOb side.
    assign w_unused = ^{axil_awprot_i, axil_arprot_i};

    // Contention goes to the direction that did not win last time.
    assign w_wr_elig  = axil_awvalid_i & axil_wvalid_i;
    assign w_rd_elig  = axil_arvalid_i;
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~r_last_wr);
    assign w_gaddr    = w_grant_wr ? axil_awaddr_i : axil_araddr_i;
    assign w_gsel     = w_gaddr[P_SLAVES +: SEL_W];
    assign w_gmapped  = (32'(w_gsel) < N_SLAVES);
    assign w_acc      = r_awready | r_arready;
    assign w_tmo      = (r_cnt >= CNT_LAST);

    // Only the latched slave's handshakes and data are visible to the FSM.
    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_rvalid = 1'b0;
        w_sel_rdata  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_sel_ready  = s_ready_i[k];
                w_sel_rvalid = s_rvalid_i[k];
                w_sel_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_last_wr <= 1'b0;
            r_is_wr   <= 1'b0;
            r_mapped  <= 1'b0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_cnt     <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_avalid  <= '0;
        end else if (cke_i) begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        // Ready pulse completes the AXI handshake this edge.
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_arready <= 1'b0;
                        if (!r_mapped) begin
                            if (r_is_wr) begin
                                r_bvalid <= 1'b1;
                                r_bresp  <= RESP_DECERR;
                                r_state  <= B_RESP;
                            end else begin
                                r_rvalid <= 1'b1;
                                r_rresp  <= RESP_DECERR;
                                r_rdata  <= '0;
                                r_state  <= R_RESP;
                            end
                        end else begin
                            r_avalid <= N_SLAVES'(1) << r_sel;
                            r_cnt    <= '0;
                            r_state  <= r_is_wr ? WR_REQ : RD_REQ;
                        end
                    end else if (w_wr_elig || w_rd_elig) begin
                        r_is_wr   <= w_grant_wr;
                        r_last_wr <= w_grant_wr;
                        r_awready <= w_grant_wr;
                        r_wready  <= w_grant_wr;
                        r_arready <= ~w_grant_wr;
                        r_sel     <= w_gsel;
                        r_mapped  <= w_gmapped;
                        r_addr    <= w_gaddr & LO_MASK;
                        r_wdata   <= w_grant_wr ? axil_wdata_i : '0;
                        r_wstrb   <= w_grant_wr ? axil_wstrb_i : '0;
                    end
                end
                WR_REQ: begin
                    if (w_sel_ready || w_tmo) begin
                        r_avalid <= '0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_sel_ready ? RESP_OKAY : RESP_SLVERR;
                        r_state  <= B_RESP;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                    end
                end
                RD_REQ: begin
                    if (w_sel_ready) begin
                        r_avalid <= '0;
                        if (w_sel_rvalid) begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= RESP_OKAY;
                            r_rdata  <= w_sel_rdata;
                            r_state  <= R_RESP;
                        end else begin
                            r_cnt   <= r_cnt + TIMEOUT_W'(1);
                            r_state <= RD_WAIT;
                        end
                    end else if (w_tmo) begin
                        r_avalid <= '0;
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_SLVERR;
                        r_rdata  <= '0;
                        r_state  <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (w_sel_rvalid || w_tmo) begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= w_sel_rvalid ? RESP_OKAY : RESP_SLVERR;
                        r_rdata  <= w_sel_rvalid ? w_sel_rdata : '0;
                        r_state  <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                    end
                end
                B_RESP: begin
                    if (axil_bready_i) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                R_RESP: begin
                    if (axil_rready_i) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign axil_awready_o = r_awready;
    assign axil_wready_o  = r_wready;
    assign axil_arready_o = r_arready;
    assign axil_bvalid_o  = r_bvalid;
    assign axil_bresp_o   = r_bresp;
    assign axil_rvalid_o  = r_rvalid;
    assign axil_rresp_o   = r_rresp;
    assign axil_rdata_o   = r_rdata;
    assign s_avalid_o     = r_avalid;
    assign s_addr_o       = r_addr;
    assign s_wdata_o      = r_wdata;
    assign s_wstrb_o      = r_wstrb;

endmodule
